// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matmul sequencing controller.
package matmul_pkg;

    localparam int DEF_N_ROWS = 4;
    localparam int DEF_N_COLS = 28;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_DATA,
        ST_CALC,
        ST_NEXT_ROW,
        ST_DONE
    } state_e;

endpackage

// File: rtl/matmul_idx_cnt.sv
// Wrapping index counter: counts 0..MAX-1, clear wins over increment.
module matmul_idx_cnt #(
    parameter int MAX = 4,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign wrap_o = (cnt_q == LAST);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i)
            cnt_d = wrap_o ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Row/column sequencer for a MAC-array matrix multiply job.
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int N_ROWS = DEF_N_ROWS,
    parameter int N_COLS = DEF_N_COLS,
    parameter int ROW_W  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
    parameter int COL_W  = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic             abort_in,
    input  logic             load_A_done,
    input  logic             load_done,
    input  logic             data_valid,
    output logic             load_A_en,
    output logic             load_en,
    output logic             ALU_en,
    output logic             row_finish,
    output logic             acc_finish,
    output logic [COL_W-1:0] col_count,
    output logic [ROW_W-1:0] row_count,
    output logic             busy,
    output logic             done
);

    state_e state_q, state_d;

    logic in_calc, in_next, in_done;
    logic col_last, row_last;
    logic col_inc, row_inc, cnt_clr;

    assign in_calc = (state_q == ST_CALC);
    assign in_next = (state_q == ST_NEXT_ROW);
    assign in_done = (state_q == ST_DONE);

    assign col_inc = in_calc & data_valid;
    assign row_inc = in_next & ~row_last;
    assign cnt_clr = abort_in | in_done;

    always_comb begin
        state_d = state_q;
        if (abort_in) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:      if (start_in) state_d = ST_LOAD_A;
                ST_LOAD_A:    if (load_A_done) state_d = ST_LOAD_DATA;
                ST_LOAD_DATA: if (load_done) state_d = ST_CALC;
                ST_CALC:      if (col_inc && col_last) state_d = ST_NEXT_ROW;
                ST_NEXT_ROW:  state_d = row_last ? ST_DONE : ST_LOAD_DATA;
                ST_DONE:      state_d = ST_IDLE;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Column counter self-wraps on the last beat, row counter steps in NEXT_ROW.
    matmul_idx_cnt #(.MAX(N_COLS), .W(COL_W)) u_col_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (col_inc),
        .clr_i  (cnt_clr),
        .cnt_o  (col_count),
        .wrap_o (col_last)
    );

    matmul_idx_cnt #(.MAX(N_ROWS), .W(ROW_W)) u_row_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (row_inc),
        .clr_i  (cnt_clr),
        .cnt_o  (row_count),
        .wrap_o (row_last)
    );

    assign load_A_en  = (state_q == ST_LOAD_A);
    assign load_en    = (state_q == ST_LOAD_DATA) | in_calc;
    assign ALU_en     = col_inc | in_next;
    assign row_finish = col_inc & col_last;
    assign acc_finish = in_next & row_last;
    assign busy       = (state_q != ST_IDLE);
    assign done       = in_done;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed self-checking bench for matmul_seq_ctrl (default and 1x1 configs).
module tb_matmul_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start_in = 0, abort_in = 0;
    logic       load_A_done = 0, load_done = 0, data_valid = 0;
    logic       load_A_en, load_en, ALU_en;
    logic       row_finish, acc_finish, busy, done;
    logic [4:0] col_count;
    logic [1:0] row_count;

    logic       start1 = 0, abort1 = 0, la1 = 0, ld1 = 0, dv1 = 0;
    logic       la_en1, ld_en1, alu1, rf1, af1, busy1, done1;
    logic [0:0] col1, row1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    matmul_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start_in    (start_in),
        .abort_in    (abort_in),
        .load_A_done (load_A_done),
        .load_done   (load_done),
        .data_valid  (data_valid),
        .load_A_en   (load_A_en),
        .load_en     (load_en),
        .ALU_en      (ALU_en),
        .row_finish  (row_finish),
        .acc_finish  (acc_finish),
        .col_count   (col_count),
        .row_count   (row_count),
        .busy        (busy),
        .done        (done)
    );

    matmul_seq_ctrl #(.N_ROWS(1), .N_COLS(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .start_in    (start1),
        .abort_in    (abort1),
        .load_A_done (la1),
        .load_done   (ld1),
        .data_valid  (dv1),
        .load_A_en   (la_en1),
        .load_en     (ld_en1),
        .ALU_en      (alu1),
        .row_finish  (rf1),
        .acc_finish  (af1),
        .col_count   (col1),
        .row_count   (row1),
        .busy        (busy1),
        .done        (done1)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle 1 is the cycle start_in is presented; handshakes are immediate.
    task automatic run_job(input bit hold, input int stall_len,
                           output int done_cyc, output int rf_n,
                           output int af_n, output int dn_n);
        int  st_left;
        bit  stalled;
        done_cyc = 0; rf_n = 0; af_n = 0; dn_n = 0;
        st_left = 0; stalled = 0;
        start_in = 1; load_A_done = 1; load_done = 1; data_valid = 1;
        for (int cyc = 1; cyc <= 400 && done_cyc == 0; cyc++) begin
            if (stall_len > 0 && !stalled && col_count == 5'd10) begin
                st_left = stall_len;
                stalled = 1;
            end
            data_valid = (st_left == 0);
            #1;
            if (st_left > 0) begin
                check_eq("stall_col", int'(col_count), 10);
                check_eq("stall_alu", int'(ALU_en), 0);
                st_left--;
            end
            rf_n += int'(row_finish);
            af_n += int'(acc_finish);
            if (done) begin
                dn_n++;
                done_cyc = cyc;
            end
            tick();
            if (!hold) start_in = 0;
        end
        data_valid = 1;
        check_eq("done_pulse_1cyc", int'(done), 0);
        check_eq("idle_after_done", int'(busy), 0);
    endtask

    task automatic wait_rc(input int r, input int c, output bit ok);
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (busy && int'(row_count) == r && int'(col_count) == c)
                ok = 1;
            else
                tick();
        end
    endtask

    int dc, rf, af, dn;
    bit ok;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_en", int'({load_A_en, load_en, ALU_en}), 0);
        check_eq("rst_col", int'(col_count), 0);
        check_eq("rst_row", int'(row_count), 0);
        check_eq("rst_busy1", int'(busy1), 0);

        run_job(0, 0, dc, rf, af, dn);
        check_eq("job_done_cyc", dc, 123);
        check_eq("job_row_fin", rf, 4);
        check_eq("job_acc_fin", af, 1);
        check_eq("job_done_n", dn, 1);

        run_job(0, 5, dc, rf, af, dn);
        check_eq("stall_done_cyc", dc, 128);
        check_eq("stall_row_fin", rf, 4);

        run_job(1, 0, dc, rf, af, dn);
        check_eq("hold_done_cyc", dc, 123);
        check_eq("hold_row_fin", rf, 4);
        check_eq("hold_done_n", dn, 1);
        tick();
        check_eq("hold_restart", int'(busy), 1);
        check_eq("hold_load_a", int'(load_A_en), 1);
        start_in = 0;
        abort_in = 1;
        tick();
        abort_in = 0;
        check_eq("abort_load_a", int'(busy), 0);

        start_in = 1;
        tick();
        start_in = 0;
        wait_rc(2, 7, ok);
        check_eq("abort_reach", int'(ok), 1);
        abort_in = 1;
        tick();
        abort_in = 0;
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_row", int'(row_count), 0);
        check_eq("abort_col", int'(col_count), 0);
        check_eq("abort_en", int'({load_A_en, load_en, ALU_en}), 0);
        dn = 0;
        for (int i = 0; i < 10; i++) begin
            dn += int'(done);
            tick();
        end
        check_eq("abort_no_done", dn, 0);

        start_in = 1;
        tick();
        start_in = 0;
        wait_rc(1, 5, ok);
        check_eq("rst_reach", int'(ok), 1);
        rst = 1;
        tick();
        rst = 0;
        check_eq("midrst_outs", int'({load_A_en, load_en, ALU_en, row_finish,
                                      acc_finish, busy, done}), 0);
        check_eq("midrst_col", int'(col_count), 0);
        check_eq("midrst_row", int'(row_count), 0);
        run_job(0, 0, dc, rf, af, dn);
        check_eq("rerun_done_cyc", dc, 123);
        check_eq("rerun_row_fin", rf, 4);

        dc = 0; rf = 0; af = 0; dn = 0;
        start1 = 1; la1 = 1; ld1 = 1; dv1 = 1;
        for (int cyc = 1; cyc <= 20 && dc == 0; cyc++) begin
            #1;
            rf += int'(rf1);
            af += int'(af1);
            if (done1) begin
                dn++;
                dc = cyc;
            end
            tick();
            start1 = 0;
        end
        check_eq("n11_done_cyc", dc, 6);
        check_eq("n11_row_fin", rf, 1);
        check_eq("n11_acc_fin", af, 1);
        check_eq("n11_done_n", dn, 1);
        check_eq("n11_idle", int'(busy1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/matmul_seq_ctrl.md
MATMUL_SEQ_CTRL -- requirements
Module: matmul_seq_ctrl

Interface
REQ-001 SHALL have parameter N_ROWS, default 4: output rows per matrix job, range 1..256.
REQ-002 SHALL have parameter N_COLS, default 28: accumulation steps per row, range 1..256.
REQ-003 SHALL have parameter ROW_W, default $clog2(N_ROWS) with minimum 1: row counter width.
REQ-004 SHALL have parameter COL_W, default $clog2(N_COLS) with minimum 1: column counter width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start_in, input, 1 bit: job request; sampled only in IDLE.
REQ-008 SHALL have port abort_in, input, 1 bit: cancels the job from any state.
REQ-009 SHALL have port load_A_done, input, 1 bit: matrix A load complete.
REQ-010 SHALL have port load_done, input, 1 bit: operand row load complete.
REQ-011 SHALL have port data_valid, input, 1 bit: operand beat available; when 0 in CALC, the block stalls.
REQ-012 SHALL have port load_A_en, output, 1 bit: drives the A-load path.
REQ-013 SHALL have port load_en, output, 1 bit: drives the operand-load path.
REQ-014 SHALL have port ALU_en, output, 1 bit: enables the MAC array.
REQ-015 SHALL have port row_finish, output, 1 bit: single-cycle pulse on the last column beat of a row.
REQ-016 SHALL have port acc_finish, output, 1 bit: single-cycle pulse when the last row completes.
REQ-017 SHALL have port col_count, output, COL_W bits: current column index.
REQ-018 SHALL have port row_count, output, ROW_W bits: current row index.
REQ-019 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-020 SHALL have port done, output, 1 bit: single-cycle job-complete pulse.

Function
REQ-021 SHALL implement the states IDLE, LOAD_A, LOAD_DATA, CALC, NEXT_ROW and DONE, all registered.
REQ-022 SHALL transition IDLE -> LOAD_A on start_in=1 and otherwise stay in IDLE; start_in in any other state has no effect.
REQ-023 SHALL transition LOAD_A -> LOAD_DATA on load_A_done=1, and LOAD_DATA -> CALC on load_done=1.
REQ-024 SHALL, in CALC with data_valid=1, increment col_count; when col_count==N_COLS-1, it pulses row_finish, clears col_count to 0 and moves to NEXT_ROW.
REQ-025 SHALL hold col_count and the state, and drive ALU_en=0, in CALC with data_valid=0 (stall).
REQ-026 SHALL, in NEXT_ROW with row_count==N_ROWS-1, pulse acc_finish and move to DONE; otherwise it increments row_count and moves to LOAD_DATA.
REQ-027 SHALL, in DONE, assert done for exactly 1 cycle, clear row_count and col_count, and return to IDLE.
REQ-028 SHALL, on abort_in=1 in any state, go to IDLE next cycle with both counters cleared and done=0; abort has priority over all other transitions.
REQ-029 SHALL decode outputs combinationally from the state: load_A_en = LOAD_A; load_en = LOAD_DATA or CALC; ALU_en = (CALC and data_valid) or NEXT_ROW.
REQ-030 SHALL, in the N_COLS=1 case, pulse row_finish on the first valid beat; in the N_ROWS=1 case, NEXT_ROW goes directly to DONE.
REQ-031 SHALL make load_done and load_A_done have no effect outside LOAD_DATA and LOAD_A respectively.
REQ-032 SHALL make the minimum job latency from start_in to done equal 2 + N_ROWS*(N_COLS+2) + 1 cycles, given that all handshakes are immediate.

Reset
REQ-033 SHALL, with rst=1 at a clock edge, set state=IDLE, col_count=0 and row_count=0, giving all 1-bit outputs 0; mid-job reset behaves identically.
REQ-034 SHALL give rst priority over abort_in and every other input.

Structure
REQ-035 SHALL place the state encoding enum and the default N_ROWS/N_COLS constants in the shared package matmul_pkg.
REQ-036 SHALL use one sub-module, matmul_idx_cnt: a parametrised wrapping counter with inc, clr, wrap-flag, instantiated twice (row, col).

Verification
REQ-037 SHALL cover a default job: with start, load_A_done and load_done each pulsed once and data_valid=1, the bench sees row_finish 4 times, acc_finish once, and done at cycle 123.
REQ-038 SHALL cover stall: data_valid=0 for 5 cycles at col_count=10 -> col_count stays at 10, ALU_en=0, and done arrives 5 cycles later.
REQ-039 SHALL cover abort: abort_in at row_count=2, col_count=7 -> next cycle IDLE, counters 0, busy=0, and no done.
REQ-040 SHALL cover reset mid-CALC: rst=1 -> all outputs 0 next cycle, and a new start_in runs a full job correctly.
REQ-041 SHALL cover N_ROWS=1, N_COLS=1: a job completes in 6 cycles, with row_finish, acc_finish and done each pulsing once.
REQ-042 SHALL cover ignored start: start_in held high during a job -> no restart; a second job starts only after returning to IDLE.
